// File: rtl/dmem_ctrl_if.sv
// Requester-side bus of the Y86-64 data-memory controller.
//
// Groups the two requester ports into one bundle:
//   Port M (memory stage): m_req, m_icode, m_valA, m_valE, m_valP in;
//                          m_done, m_valM, m_err, m_stall out.
//   Port L (loader/debug): l_req, l_we, l_addr, l_wdata in;
//                          l_done, l_rdata, l_err out.
// Modports:
//   master - the requesters (pipeline memory stage and loader).
//   slave  - the controller (dmem_ctrl).
interface dmem_ctrl_if;
  logic        m_req;
  logic [3:0]  m_icode;
  logic [63:0] m_valA;
  logic [63:0] m_valE;
  logic [63:0] m_valP;
  logic        m_done;
  logic [63:0] m_valM;
  logic        m_err;
  logic        m_stall;

  logic        l_req;
  logic        l_we;
  logic [63:0] l_addr;
  logic [63:0] l_wdata;
  logic        l_done;
  logic [63:0] l_rdata;
  logic        l_err;

  modport master (
    output m_req, m_icode, m_valA, m_valE, m_valP,
    output l_req, l_we, l_addr, l_wdata,
    input  m_done, m_valM, m_err, m_stall,
    input  l_done, l_rdata, l_err
  );

  modport slave (
    input  m_req, m_icode, m_valA, m_valE, m_valP,
    input  l_req, l_we, l_addr, l_wdata,
    output m_done, m_valM, m_err, m_stall,
    output l_done, l_rdata, l_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller/arbiter for the Y86-64 core.
//
// Shares one external synchronous single-port RAM between the memory stage
// (port M) and the program loader (port L). Decodes the Y86 memory semantics
// of the memory-stage instruction, range-checks word addresses, runs a
// single RAM access per grant and returns data, a done pulse and an error
// flag to the granted requester.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   bus       - requester bundle (dmem_ctrl_if.slave), ports M and L
//   ram_en    - RAM enable (one cycle per granted access)
//   ram_we    - RAM write enable
//   ram_addr  - RAM word address
//   ram_wdata - RAM write data
//   ram_rdata - RAM read data, valid the cycle after a read enable
module dmem_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_ctrl_if.slave    bus,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  localparam logic        PORT_M    = 1'b0;
  localparam logic        PORT_L    = 1'b1;
  localparam logic [63:0] DEPTH_LIM = 64'(DEPTH);

  state_t        state_reg, state_next;
  logic          rr_last_reg, rr_last_next;
  logic          port_reg, port_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          err_reg, err_next;

  logic          m_done_reg, l_done_reg, m_err_reg, l_err_reg;
  logic [DW-1:0] m_valm_reg, l_rdata_reg;
  logic          ram_en_reg, ram_we_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_wdata_reg;

  // Memory-stage decode: what the instruction wants from data memory.
  logic          m_we, m_noop, m_illegal;
  logic [63:0]   m_addr;
  logic [DW-1:0] m_wdata;

  always_comb begin
    m_we      = 1'b0;
    m_noop    = 1'b0;
    m_illegal = 1'b0;
    m_addr    = bus.m_valE;
    m_wdata   = bus.m_valA;
    case (bus.m_icode)
      4'd4, 4'd10: m_we = 1'b1;                     // rmmovq, pushq
      4'd8: begin                                   // call pushes return address
        m_we    = 1'b1;
        m_wdata = bus.m_valP;
      end
      4'd5: m_we = 1'b0;                            // mrmovq
      4'd9, 4'd11: m_addr = bus.m_valA;             // ret, popq read via stack ptr
      4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7: m_noop = 1'b1;
      default: m_illegal = 1'b1;
    endcase
  end

  // Round-robin: on a tie the port that was not granted last wins.
  logic grant_m, grant_l;
  assign grant_m = bus.m_req & (~bus.l_req | (rr_last_reg == PORT_L));
  assign grant_l = bus.l_req & ~grant_m;

  logic          sel_we, sel_noop, sel_bad;
  logic [63:0]   sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    if (grant_m) begin
      sel_we    = m_we;
      sel_noop  = m_noop;
      sel_addr  = m_addr;
      sel_wdata = m_wdata;
      // No-op instructions never touch memory, so their address is not checked.
      sel_bad   = m_illegal | (~m_noop & (m_addr >= DEPTH_LIM));
    end else begin
      sel_we    = bus.l_we;
      sel_noop  = 1'b0;
      sel_addr  = bus.l_addr;
      sel_wdata = bus.l_wdata;
      sel_bad   = (bus.l_addr >= DEPTH_LIM);
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_last_next = rr_last_reg;
    port_next    = port_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (grant_m | grant_l) begin
          port_next    = grant_l ? PORT_L : PORT_M;
          rr_last_next = grant_l ? PORT_L : PORT_M;
          we_next      = sel_we;
          addr_next    = sel_addr[AW-1:0];
          wdata_next   = sel_wdata;
          err_next     = sel_bad;
          state_next   = (sel_bad | sel_noop) ? DONE : ISSUE;
        end
      end
      ISSUE:   state_next = RESP;
      RESP:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they are
  // glitch-free Moore outputs that line up with the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_last_reg   <= PORT_L;
      port_reg      <= PORT_M;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      m_done_reg    <= 1'b0;
      l_done_reg    <= 1'b0;
      m_err_reg     <= 1'b0;
      l_err_reg     <= 1'b0;
      m_valm_reg    <= '0;
      l_rdata_reg   <= '0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
      port_reg    <= port_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      err_reg     <= err_next;

      ram_en_reg <= (state_next == ISSUE);
      ram_we_reg <= (state_next == ISSUE) & we_next;
      if (state_next == ISSUE) begin
        ram_addr_reg  <= addr_next;
        ram_wdata_reg <= wdata_next;
      end

      m_done_reg <= (state_next == DONE) & (port_next == PORT_M);
      l_done_reg <= (state_next == DONE) & (port_next == PORT_L);
      m_err_reg  <= (state_next == DONE) & (port_next == PORT_M) & err_next;
      l_err_reg  <= (state_next == DONE) & (port_next == PORT_L) & err_next;

      // RAM data is valid during RESP; only the owner of a read sees it.
      if ((state_reg == RESP) && !we_reg) begin
        if (port_reg == PORT_L) l_rdata_reg <= ram_rdata;
        else                    m_valm_reg  <= ram_rdata;
      end
    end
  end

  assign bus.m_done  = m_done_reg;
  assign bus.m_err   = m_err_reg;
  assign bus.m_valM  = m_valm_reg;
  assign bus.m_stall = bus.m_req & ~m_done_reg;
  assign bus.l_done  = l_done_reg;
  assign bus.l_err   = l_err_reg;
  assign bus.l_rdata = l_rdata_reg;

  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed steps followed by randomized traffic,
// checked against a word-array reference of data memory.
module tb_dmem_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  dmem_ctrl_if bus();

  dmem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] seed_word(input int i);
    return {32'hC0DE_0000, 32'(i)};
  endfunction

  // Synchronous single-port RAM model, preloaded on the first edge.
  logic [63:0] ram_mem [DEPTH];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= seed_word(i);
      ram_ready <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // RAM activity monitor.
  int          en_cnt = 0;
  int          we_cnt = 0;
  logic [63:0] last_addr = '0;
  logic [63:0] last_wdata = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      if (ram_we) begin
        we_cnt     <= we_cnt + 1;
        last_addr  <= 64'(ram_addr);
        last_wdata <= ram_wdata;
      end
    end
  end

  // Reference state.
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] exp_valm  = '0;
  logic [63:0] exp_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for the done pulse of one port, counting cycles.
  task automatic await_done(input bit port_l, output int lat, output bit stall_bad,
                            output bit other_bad);
    bit done;
    done = 1'b0; lat = 0; stall_bad = 1'b0; other_bad = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (port_l ? bus.m_done : bus.l_done) other_bad = 1'b1;
      done = port_l ? bus.l_done : bus.m_done;
      if (!port_l && (bus.m_stall !== !done)) stall_bad = 1'b1;
    end
  endtask

  task automatic run_m(input logic [3:0] icode, input logic [63:0] va, ve, vp);
    bit wr, rd, noop, bad, sb, ob;
    logic [63:0] addr, data;
    int lat, exp_lat, en0, we0;
    wr   = icode inside {4'd4, 4'd8, 4'd10};
    rd   = icode inside {4'd5, 4'd9, 4'd11};
    noop = (icode <= 4'd7) && !wr && !rd;
    addr = (icode == 4'd9 || icode == 4'd11) ? va : ve;
    data = (icode == 4'd8) ? vp : va;
    bad  = (icode >= 4'd12) || ((wr || rd) && addr >= 64'(DEPTH));
    exp_lat = (bad || noop) ? 1 : 3;
    en0 = en_cnt; we0 = we_cnt;
    bus.m_icode = icode; bus.m_valA = va; bus.m_valE = ve; bus.m_valP = vp;
    bus.m_req = 1'b1;
    await_done(1'b0, lat, sb, ob);
    if (rd && !bad) exp_valm = ref_mem[addr[AW-1:0]];
    chk("m_latency", 64'(lat), 64'(exp_lat));
    chk("m_err", 64'(bus.m_err), 64'(bad));
    chk("m_valM", bus.m_valM, exp_valm);
    chk("m_ram_en_cycles", 64'(en_cnt - en0), (bad || noop) ? 64'd0 : 64'd1);
    chk("m_ram_we_cycles", 64'(we_cnt - we0), (wr && !bad) ? 64'd1 : 64'd0);
    if (wr && !bad) begin
      chk("m_wr_addr", last_addr, addr);
      chk("m_wr_data", last_wdata, data);
      ref_mem[addr[AW-1:0]] = data;
    end
    chk("m_stall", 64'(sb), 64'd0);
    chk("m_other_done", 64'(ob), 64'd0);
    bus.m_req = 1'b0;
    @(negedge clk);
    chk("m_done_pulse", 64'(bus.m_done), 64'd0);
    $display("txn M icode=%0d addr=%0h data=%0h lat=%0d err=%0b valM=%0h",
             icode, addr, data, lat, bad, exp_valm);
  endtask

  task automatic run_l(input bit we, input logic [63:0] addr, input logic [63:0] wdata);
    bit bad, sb, ob;
    int lat, exp_lat, en0, we0;
    bad = (addr >= 64'(DEPTH));
    exp_lat = bad ? 1 : 3;
    en0 = en_cnt; we0 = we_cnt;
    bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
    bus.l_req = 1'b1;
    await_done(1'b1, lat, sb, ob);
    if (!we && !bad) exp_rdata = ref_mem[addr[AW-1:0]];
    chk("l_latency", 64'(lat), 64'(exp_lat));
    chk("l_err", 64'(bus.l_err), 64'(bad));
    chk("l_rdata", bus.l_rdata, exp_rdata);
    chk("l_ram_en_cycles", 64'(en_cnt - en0), bad ? 64'd0 : 64'd1);
    chk("l_ram_we_cycles", 64'(we_cnt - we0), (we && !bad) ? 64'd1 : 64'd0);
    if (we && !bad) begin
      chk("l_wr_addr", last_addr, addr);
      chk("l_wr_data", last_wdata, wdata);
      ref_mem[addr[AW-1:0]] = wdata;
    end
    chk("l_other_done", 64'(ob), 64'd0);
    bus.l_req = 1'b0;
    @(negedge clk);
    chk("l_done_pulse", 64'(bus.l_done), 64'd0);
    $display("txn L we=%0b addr=%0h wdata=%0h lat=%0d err=%0b rdata=%0h",
             we, addr, wdata, lat, bad, exp_rdata);
  endtask

  function automatic logic [63:0] gen_addr();
    case ($urandom_range(0, 9))
      0:       return 64'd1024 + 64'($urandom_range(0, 3));
      1:       return {32'h1, $urandom};
      2:       return 64'd1023;
      default: return 64'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    int m_t, l_t, en0, nd;
    logic m_e, l_e;
    logic [63:0] l_d;
    int order [3];
    int when [3];

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    rst_n = 1'b0;
    bus.m_req = 1'b0; bus.m_icode = '0; bus.m_valA = '0; bus.m_valE = '0; bus.m_valP = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_m_done", 64'(bus.m_done), 64'd0);
    chk("rst_l_done", 64'(bus.l_done), 64'd0);
    chk("rst_m_err", 64'(bus.m_err), 64'd0);
    chk("rst_l_err", 64'(bus.l_err), 64'd0);
    chk("rst_m_valM", bus.m_valM, 64'd0);
    chk("rst_l_rdata", bus.l_rdata, 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", ram_wdata, 64'd0);
    chk("rst_m_stall", 64'(bus.m_stall), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both ports request together after reset: M (write 7) first, then L reads it.
    en0 = en_cnt;
    bus.m_icode = 4'd4; bus.m_valE = 64'd7; bus.m_valA = 64'h1111_2222_3333_4444;
    bus.m_valP = '0; bus.m_req = 1'b1;
    bus.l_we = 1'b0; bus.l_addr = 64'd7; bus.l_wdata = '0; bus.l_req = 1'b1;
    m_t = 0; l_t = 0; m_e = 1'bx; l_e = 1'bx; l_d = 'x;
    for (int c = 1; c <= 30 && (m_t == 0 || l_t == 0); c++) begin
      @(negedge clk);
      if (bus.m_done) begin m_t = c; m_e = bus.m_err; bus.m_req = 1'b0; end
      if (bus.l_done) begin l_t = c; l_e = bus.l_err; l_d = bus.l_rdata; bus.l_req = 1'b0; end
    end
    @(negedge clk);
    ref_mem[7] = 64'h1111_2222_3333_4444;
    exp_rdata = ref_mem[7];
    chk("tie_m_done_cycle", 64'(m_t), 64'd3);
    chk("tie_l_done_cycle", 64'(l_t), 64'd7);
    chk("tie_m_err", 64'(m_e), 64'd0);
    chk("tie_l_err", 64'(l_e), 64'd0);
    chk("tie_l_rdata", l_d, exp_rdata);
    chk("tie_ram_en_cycles", 64'(en_cnt - en0), 64'd2);
    $display("txn TIE m_done@%0d l_done@%0d l_rdata=%0h", m_t, l_t, l_d);

    // Directed M write / read / error / no-op.
    run_m(4'd4, 64'hDEAD, 64'd5, 64'd0);
    run_m(4'd9, 64'd5, 64'h1234, 64'h5678);
    run_m(4'd5, 64'd0, 64'd1024, 64'd0);
    run_m(4'd15, 64'd3, 64'd3, 64'd3);
    run_m(4'd6, 64'd3, 64'd3, 64'd3);
    run_m(4'd8, 64'd2000, 64'd9, 64'h0000_0000_0040_0100);
    run_m(4'd11, 64'd9, 64'd0, 64'd0);

    // Loader at the top word.
    run_l(1'b1, 64'd1023, 64'hFEED_FACE_CAFE_BEEF);
    run_l(1'b0, 64'd1023, 64'd0);

    // Both held continuously: grants alternate M, L, M.
    en0 = en_cnt;
    bus.m_icode = 4'd10; bus.m_valE = 64'd20; bus.m_valA = 64'hAAAA_0020; bus.m_req = 1'b1;
    bus.l_we = 1'b1; bus.l_addr = 64'd21; bus.l_wdata = 64'hBBBB_0021; bus.l_req = 1'b1;
    nd = 0;
    for (int c = 1; c <= 40 && nd < 3; c++) begin
      @(negedge clk);
      if (bus.m_done) begin order[nd] = 0; when[nd] = c; nd++; end
      if (bus.l_done) begin order[nd] = 1; when[nd] = c; nd++; end
      if (nd >= 3) begin bus.m_req = 1'b0; bus.l_req = 1'b0; end
    end
    bus.m_req = 1'b0; bus.l_req = 1'b0;
    @(negedge clk);
    ref_mem[20] = 64'hAAAA_0020;
    ref_mem[21] = 64'hBBBB_0021;
    chk("alt_grants", 64'(nd), 64'd3);
    chk("alt_first_port", 64'(order[0]), 64'd0);
    chk("alt_second_port", 64'(order[1]), 64'd1);
    chk("alt_third_port", 64'(order[2]), 64'd0);
    chk("alt_third_cycle", 64'(when[2]), 64'd11);
    chk("alt_ram_en_cycles", 64'(en_cnt - en0), 64'd3);
    $display("txn ALT ports=%0d,%0d,%0d at %0d,%0d,%0d",
             order[0], order[1], order[2], when[0], when[1], when[2]);
    run_l(1'b0, 64'd20, 64'd0);
    run_m(4'd11, 64'd21, 64'd0, 64'd0);

    // Reset during RESP of an M read.
    bus.m_icode = 4'd5; bus.m_valE = 64'd5; bus.m_valA = '0; bus.m_valP = '0;
    bus.m_req = 1'b1;
    @(negedge clk);
    chk("abort_issue_en", 64'(ram_en), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_m_done", 64'(bus.m_done), 64'd0);
    chk("abort_m_valM", bus.m_valM, 64'd0);
    chk("abort_l_rdata", bus.l_rdata, 64'd0);
    chk("abort_ram_en", 64'(ram_en), 64'd0);
    chk("abort_ram_addr", 64'(ram_addr), 64'd0);
    chk("abort_ram_wdata", ram_wdata, 64'd0);
    bus.m_req = 1'b0;
    rst_n = 1'b1;
    exp_valm = '0;
    exp_rdata = '0;
    @(negedge clk);
    chk("abort_no_late_done", 64'(bus.m_done), 64'd0);
    $display("txn RESET-ABORT m_done=%0b", bus.m_done);
    run_l(1'b0, 64'd5, 64'd0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [3:0]  ic;
        logic [63:0] va, ve, vp;
        ic = 4'($urandom_range(0, 15));
        va = {$urandom, $urandom};
        ve = {$urandom, $urandom};
        vp = {$urandom, $urandom};
        if (ic == 4'd9 || ic == 4'd11) va = gen_addr();
        else                           ve = gen_addr();
        run_m(ic, va, ve, vp);
      end else begin
        run_l(1'($urandom_range(0, 1)), gen_addr(), {$urandom, $urandom});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller/arbiter for the SEQ/PIPE Y86-64 core.
- Shares one external synchronous single-port data RAM between two requesters:
  - Port M: the memory stage, driven by icode/valA/valE/valP.
  - Port L: the program loader/debug port, with generic address/data.
- Decodes Y86 memory semantics, range-checks addresses, sequences the RAM access, and returns data, a done pulse and dmem_error per requester.

Parameters:
- DEPTH, 1024, number of 64-bit RAM words; legal addresses are 0..DEPTH-1.
- AW, 10, RAM address width, log2(DEPTH).
- DW, 64, data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- m_req  in  1  memory-stage request; held high until m_done.
- m_icode  in  4  instruction code of the requesting instruction.
- m_valA  in  64  valA.
- m_valE  in  64  valE.
- m_valP  in  64  valP.
- m_done  out  1  one-cycle completion pulse to the memory stage.
- m_valM  out  64  read data; valid while m_done=1 and held afterwards.
- m_err  out  1  dmem_error; valid while m_done=1.
- m_stall  out  1  m_req & ~m_done (combinational), used to stall the pipeline.
- l_req  in  1  loader request; held high until l_done.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  64  word address.
- l_wdata  in  64  write data.
- l_done  out  1  one-cycle completion pulse to the loader.
- l_rdata  out  64  read data; valid while l_done=1 and held afterwards.
- l_err  out  1  address error; valid while l_done=1.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data; valid the cycle after an ram_en=1 & ram_we=0 cycle.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state := IDLE; rr_last := L, so port M wins the first tie.
  - All registered outputs := 0: m_done, l_done, m_err, l_err, m_valM, l_rdata, ram_en, ram_we, ram_addr, ram_wdata.
- Port M decode (addresses are word indices, not byte addresses):
  - icode 4 (rmmovq): write, addr valE, data valA.
  - icode 10 (pushq): write, addr valE, data valA.
  - icode 8 (call): write, addr valE, data valP.
  - icode 5 (mrmovq): read, addr valE.
  - icode 9 (ret): read, addr valA.
  - icode 11 (popq): read, addr valA.
  - icode 0,1,2,3,6,7: no memory op.
  - icode 12-15: illegal.
- State machine, registered Moore outputs:
  - IDLE: arbitrate among asserted requests.
    - Only one requester asserts: grant it.
    - Both assert: grant the port that is not rr_last.
    - On grant, latch op, addr, wdata and port id, and set rr_last := granted port. Later input changes are ignored.
    - No-memory-op icode: go to DONE, err=0, no RAM access.
    - Illegal icode, or addr >= DEPTH (unsigned, full 64-bit compare): go to DONE, err=1, ram_en stays 0.
    - Otherwise go to ISSUE.
  - ISSUE: ram_en=1; ram_we=op; ram_addr=addr[AW-1:0]; ram_wdata=wdata. Next state RESP.
  - RESP: ram_en=0, ram_we=0. Capture ram_rdata into the granted port's data register on reads only; writes leave it unchanged. Next state DONE.
  - DONE: granted port's done=1 and err as decided. The other port's done stays 0. Next state IDLE.
- Latency (request sampled at IDLE edge k):
  - Normal access: done high in the cycle after edge k+2, i.e. 3 cycles. The next request can be sampled at edge k+4, so one access per 4 cycles.
  - Error or no-op: done high in the cycle after edge k, i.e. 1 cycle. IDLE resumes at edge k+1.
  - The DONE→IDLE step guarantees a requester that drops req during its done cycle is never re-granted.
- A requester that keeps req high after done is treated as a new request. The round-robin pointer then favours the other port if it is waiting.
- At most one ram_en cycle per grant; ram_en never asserts in IDLE, RESP or DONE.
- Reset mid-operation:
  - Abort to IDLE; no done pulse is issued.
  - A write whose ISSUE cycle already occurred is committed by the RAM; the controller does not undo it.
- Requesters never receive partial data: m_valM/l_rdata change only at RESP of their own read.

Test Plan:
- M write: m_icode=4, m_valE=5, m_valA=0xDEAD, held → exactly one ISSUE cycle with ram_we=1, ram_addr=5, ram_wdata=0xDEAD; m_done 3 cycles after the sampling edge, m_err=0.
- M read: m_icode=9, m_valA=5, RAM model returns 0xDEAD → m_valM=0xDEAD with m_done; ram_we=0 throughout; m_stall=1 until m_done.
- Range/illegal: m_icode=5, m_valE=1024 → m_done and m_err=1 one cycle later, ram_en never 1. Repeat with m_icode=0xF → m_err=1. Repeat with m_icode=6 → m_err=0, no ram_en.
- Arbitration:
  - m_req and l_req both rise in the same cycle after reset → M served first, then L.
  - Both held continuously → grants alternate M, L, M.
  - l_req alone with l_addr=1023 write → served, l_err=0.
- Reset mid-op: assert rst_n=0 during RESP of an M read → no m_done pulse, all outputs 0 the next cycle, state IDLE. A fresh L read after reset completes normally.
